// File: rtl/fnd_apb_scheduler.sv
// rtl/fnd_apb_scheduler.sv - round-robin APB master sharing the FND register bus among requesters
module fnd_apb_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [4*NUM_REQ-1:0]  req_addr,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    done,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [3:0]            PADDR,
    output logic [31:0]           PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [31:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 busy_q, busy_d;
    logic [3:0]           paddr_q, paddr_d;
    logic [31:0]          pwdata_q, pwdata_d;
    logic                 pwrite_q, pwrite_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;

    logic                 gnt_found;
    logic [IW-1:0]        gnt_idx;
    logic                 gnt_write;
    logic [3:0]           gnt_addr;
    logic [31:0]          gnt_wdata;

    // Round-robin pick: first set req bit searching circularly from ptr+1
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_write = 1'b0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int            c;
            logic [IW-1:0] ci;
            c = int'(ptr_q) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            ci = IW'(c);
            if (!gnt_found && req[ci]) begin
                gnt_found = 1'b1;
                gnt_idx   = ci;
                gnt_write = req_write[ci];
                gnt_addr  = 4'(req_addr >> (4 * c));
                gnt_wdata = 32'(req_wdata >> (32 * c));
            end
        end
    end

    // Next-state and registered-output logic; outputs change together with the state
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        done_d      = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        busy_d      = busy_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    idx_d     = gnt_idx;
                    ptr_d     = gnt_idx;
                    pwrite_d  = gnt_write;
                    // Byte lanes are not supported: unaligned addresses fold to the word
                    paddr_d   = gnt_addr & 4'hC;
                    pwdata_d  = gnt_write ? gnt_wdata : 32'h0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                // PREADY wins over a timeout landing in the same cycle
                if (PREADY || (cnt_q == CW'(TIMEOUT - 1))) begin
                    done_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;
                    rsp_err_d   = !PREADY;
                    rsp_rdata_d = (PREADY && !pwrite_q) ? PRDATA : 32'h0;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    paddr_d     = '0;
                    pwdata_d    = '0;
                    pwrite_d    = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the bus immediately
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q     <= S_IDLE;
            ptr_q       <= IW'(NUM_REQ - 1);
            idx_q       <= '0;
            cnt_q       <= '0;
            done_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
        end
    end

    assign done      = done_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;

endmodule

// File: tb/tb_fnd_apb_scheduler.sv
// tb/tb_fnd_apb_scheduler.sv - directed vector bench for fnd_apb_scheduler
module tb_fnd_apb_scheduler;

    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic [1:0]    req;
    logic [1:0]    req_write;
    logic [7:0]    req_addr;
    logic [63:0]   req_wdata;
    logic [1:0]    done;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic [3:0]    PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA;
    logic          PREADY;

    int n_tests = 0;
    int n_fail  = 0;

    fnd_apb_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    // FND slave model: registered PREADY one cycle after PSEL&PENABLE
    logic [31:0] mem [4];
    logic        slave_en;
    always @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            PREADY <= 1'b0;
            PRDATA <= 32'h0;
        end else if (PSEL && PENABLE && !PREADY && slave_en) begin
            PREADY <= 1'b1;
            if (PWRITE) mem[PADDR[3:2]] <= PWDATA;
            PRDATA <= PWRITE ? 32'h0 : mem[PADDR[3:2]];
        end else begin
            PREADY <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int ch, input bit wr, input logic [3:0] a, input logic [31:0] d);
        req_write[ch]        = wr;
        req_addr[4*ch +: 4]  = a;
        req_wdata[32*ch +: 32] = d;
    endtask

    task automatic wait_setup(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (PSEL && !PENABLE) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns once done is seen; acc counts ACCESS cycles observed before it
    task automatic wait_done(output bit ok, output int acc);
        ok  = 1'b0;
        acc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            if (done != 2'b00) begin
                ok = 1'b1;
                break;
            end
            if (PSEL && PENABLE) acc++;
        end
    endtask

    typedef struct {
        int          ch;
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  exp_paddr;
        logic [31:0] exp_pwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit          ok;
        int          acc;
        int          extra;
        logic [1:0]  ord [3];

        vecs[0] = '{0, 1'b1, 4'h4, 32'h0000_04D2, 4'h4, 32'h0000_04D2, 32'h0};
        vecs[1] = '{1, 1'b1, 4'h8, 32'h0000_0003, 4'h8, 32'h0000_0003, 32'h0};
        vecs[2] = '{0, 1'b0, 4'h8, 32'hDEAD_BEEF, 4'h8, 32'h0,         32'h0000_0003};
        vecs[3] = '{1, 1'b0, 4'h4, 32'h0,         4'h4, 32'h0,         32'h0000_04D2};
        vecs[4] = '{0, 1'b1, 4'h5, 32'h0000_00AB, 4'h4, 32'h0000_00AB, 32'h0};
        vecs[5] = '{1, 1'b0, 4'h6, 32'h1234_5678, 4'h4, 32'h0,         32'h0000_00AB};
        vecs[6] = '{0, 1'b1, 4'h0, 32'hFFFF_FFFF, 4'h0, 32'hFFFF_FFFF, 32'h0};
        vecs[7] = '{1, 1'b0, 4'h3, 32'h0,         4'h0, 32'h0,         32'hFFFF_FFFF};
        ord[0] = 2'b01;
        ord[1] = 2'b10;
        ord[2] = 2'b01;

        PRESET    = 1'b0;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        slave_en  = 1'b1;
        repeat (2) @(negedge PCLK);
        check("reset_ctrl", 64'({PSEL, PENABLE, PWRITE, busy, done, rsp_err}), 64'h0);
        check("reset_data", 64'({PADDR, PWDATA}), 64'h0);
        check("reset_rdata", 64'(rsp_rdata), 64'h0);
        PRESET = 1'b1;

        // All requesters held high after reset: grants rotate 0,1,0
        set_ch(0, 1'b1, 4'h0, 32'h0000_0011);
        set_ch(1, 1'b1, 4'hC, 32'h0000_0022);
        req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_done(ok, acc);
            check($sformatf("rr%0d_seen", k), 64'(ok), 64'h1);
            check($sformatf("rr%0d_done", k), 64'(done), 64'(ord[k]));
            if (k == 2) req = 2'b00;
        end
        @(negedge PCLK);
        check("rr_done_clear", 64'(done), 64'h0);

        // Single-requester vectors
        for (int v = 0; v < 8; v++) begin
            set_ch(vecs[v].ch, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
            req = '0;
            req[vecs[v].ch] = 1'b1;
            wait_setup(ok);
            check($sformatf("v%0d_setup_seen", v), 64'(ok), 64'h1);
            check($sformatf("v%0d_paddr", v), 64'(PADDR), 64'(vecs[v].exp_paddr));
            check($sformatf("v%0d_pwrite", v), 64'(PWRITE), 64'(vecs[v].wr));
            check($sformatf("v%0d_pwdata", v), 64'(PWDATA), 64'(vecs[v].exp_pwdata));
            check($sformatf("v%0d_busy", v), 64'(busy), 64'h1);
            wait_done(ok, acc);
            check($sformatf("v%0d_done_seen", v), 64'(ok), 64'h1);
            check($sformatf("v%0d_access_cycles", v), 64'(acc), 64'd2);
            check($sformatf("v%0d_done", v), 64'(done), 64'(2'b01 << vecs[v].ch));
            check($sformatf("v%0d_rdata", v), 64'(rsp_rdata), 64'(vecs[v].exp_rdata));
            check($sformatf("v%0d_err", v), 64'(rsp_err), 64'h0);
            check($sformatf("v%0d_psel_done", v), 64'({PSEL, PENABLE}), 64'h0);
            req = '0;
            if (vecs[v].wr)
                check($sformatf("v%0d_slave_reg", v), 64'(mem[vecs[v].addr[3:2]]), 64'(vecs[v].wdata));
            @(negedge PCLK);
        end

        // Slave never answers: ACCESS lasts TIMEOUT cycles, error completion
        slave_en = 1'b0;
        set_ch(1, 1'b0, 4'h4, 32'h0);
        req = 2'b10;
        wait_setup(ok);
        check("to_setup_seen", 64'(ok), 64'h1);
        wait_done(ok, acc);
        check("to_done_seen", 64'(ok), 64'h1);
        check("to_access_cycles", 64'(acc), 64'(TIMEOUT));
        check("to_done", 64'(done), 64'h2);
        check("to_err", 64'(rsp_err), 64'h1);
        check("to_rdata", 64'(rsp_rdata), 64'h0);
        check("to_psel", 64'(PSEL), 64'h0);
        req = 2'b00;
        slave_en = 1'b1;
        @(negedge PCLK);

        // Reset during ACCESS drops the bus at once and discards the request
        set_ch(0, 1'b1, 4'h0, 32'h0000_0055);
        set_ch(1, 1'b0, 4'h8, 32'h0);
        req = 2'b01;
        wait_setup(ok);
        check("mr_setup_seen", 64'(ok), 64'h1);
        @(negedge PCLK);
        check("mr_in_access", 64'({PSEL, PENABLE}), 64'h3);
        PRESET = 1'b0;
        #1;
        check("mr_ctrl", 64'({PSEL, PENABLE, PWRITE, busy, done, rsp_err}), 64'h0);
        check("mr_data", 64'({PADDR, PWDATA}), 64'h0);
        req = 2'b11;
        @(negedge PCLK);
        check("mr_no_done", 64'({done, PSEL}), 64'h0);
        PRESET = 1'b1;
        wait_done(ok, acc);
        check("mr_after_seen", 64'(ok), 64'h1);
        check("mr_after_grant", 64'(done), 64'h1);
        req = 2'b00;
        @(negedge PCLK);

        // Unaligned address, request dropped in SETUP: one done, no re-grant
        set_ch(0, 1'b1, 4'h5, 32'h0000_0077);
        req = 2'b01;
        wait_setup(ok);
        check("dr_setup_seen", 64'(ok), 64'h1);
        check("dr_paddr", 64'(PADDR), 64'h4);
        req = 2'b00;
        wait_done(ok, acc);
        check("dr_done_seen", 64'(ok), 64'h1);
        check("dr_done", 64'(done), 64'h1);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            if (done != 2'b00 || PSEL) extra++;
        end
        check("dr_no_extra", 64'(extra), 64'h0);
        check("dr_slave_reg", 64'(mem[1]), 64'h77);
        check("dr_idle_busy", 64'(busy), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
